// File: rtl/seg_mux_capture.sv
// Receive side of the two-digit multiplexed 7-segment link.
// Debounces each digit, decodes glyphs to hex and assembles {hi, lo} codes.
module seg_mux_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic [1:0] an_in,
  output logic [7:0] code_out,
  output logic       code_valid,
  output logic       code_changed,
  output logic       pat_err,
  output logic       busy
);

  localparam logic [7:0] STB = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    GOT_LO,
    GOT_HI
  } state_t;

  logic [8:0] sync1_q;
  logic [8:0] sync2_q;
  logic [8:0] samp_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       done_q;
  logic       done_d;
  logic [6:0] s_seg;
  logic [1:0] s_an;
  logic       eq;
  logic       an_lo;
  logic       an_hi;
  logic       acc;
  logic       legal;
  logic [3:0] nib;
  state_t     state_q;
  state_t     state_d;
  logic [3:0] lo_q;
  logic [3:0] lo_d;
  logic [3:0] hi_q;
  logic [3:0] hi_d;
  logic       perr_d;
  logic       first_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      samp_q  <= '0;
    end else begin
      sync1_q <= {seg_in, an_in};
      sync2_q <= sync1_q;
      samp_q  <= sync2_q;
    end
  end

  assign s_seg = samp_q[8:2] ^ {7{SEG_ACTIVE_LOW}};
  assign s_an  = samp_q[1:0] ^ {2{AN_ACTIVE_LOW}};
  assign eq    = (sync2_q == samp_q);
  assign an_lo = (s_an == 2'b01);
  assign an_hi = (s_an == 2'b10);

  // Fires on the edge where the dwell counter reaches STB.
  assign acc = eq && (cnt_q == STB - 8'd1) && !done_q
               && (an_lo || an_hi);

  always_comb begin
    cnt_d  = 8'd1;
    done_d = 1'b0;
    if (eq) begin
      cnt_d  = (cnt_q == STB) ? cnt_q : cnt_q + 8'd1;
      done_d = done_q | acc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    case (s_seg)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    perr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc && an_lo) begin
          if (legal) begin
            lo_d    = nib;
            state_d = GOT_LO;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      GOT_LO: begin
        if (acc) begin
          if (!legal) begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end else if (an_hi) begin
            hi_d    = nib;
            state_d = GOT_HI;
          end else begin
            lo_d = nib;
          end
        end
      end
      GOT_HI: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_out     <= '0;
      code_valid   <= 1'b0;
      code_changed <= 1'b0;
      pat_err      <= 1'b0;
      first_q      <= 1'b1;
    end else begin
      code_valid   <= (state_q == GOT_HI);
      code_changed <= 1'b0;
      pat_err      <= perr_d;
      if (state_q == GOT_HI) begin
        code_out     <= {hi_q, lo_q};
        code_changed <= first_q || ({hi_q, lo_q} != code_out);
        first_q      <= 1'b0;
      end
    end
  end

  assign busy = (state_q == GOT_LO);

endmodule
